opb_register_ppc2simulink: RTL and testbench
============================================

Name: opb_register_ppc2simulink

Overview:
- OPB slave register that carries software-written data from the PowerPC into Simulink user logic. It is the write-direction counterpart of the simulink2ppc status register.
- The PPC writes a 32-bit control word with byte-lane granularity. User logic sees it on user_data_out, plus a one-cycle update strobe.
- Sits on the same OPB bus as the other register slaves, with its own address window.
- Single clock domain: user logic runs on OPB_Clk.

Parameters:
- C_BASEADDR, 32'h01080700, first byte address of the slave window.
- C_HIGHADDR, 32'h010807FF, last byte address of the window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_RESET_VAL, 32'h00000000, reset value of user_data_out.
- C_FAMILY, "virtex5", target family; informational only.

Ports:
- OPB_Clk  in  1  sole clock; bus and user side.
- OPB_Rst  in  1  asynchronous, active-high reset.
- OPB_ABus  in  [0:31]  address, bit 0 = MSB.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transfer request.
- OPB_seqAddr  in  1  sequential burst hint; ignored.
- Sl_DBus  out  [0:31]  read data; zero except during a read ack.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- user_data_out  out  [31:0]  current register value to user logic.
- user_data_valid  out  1  one-cycle pulse when the register is written.

Behaviour:
- Decode:
  - hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR) && !Sl_xferAck.
  - Word offset = OPB_ABus[C_OPB_AWIDTH-8 +: 6] masked to bits [5:2] of the address.
- Address map:
  - 0x0: DATA, read/write.
  - 0x4: WRCOUNT, read-only (see Optional Feature).
  - All other in-window offsets read 0; writes to them are acked and ignored.
- Transfer FSM, states IDLE and ACK:
  - IDLE → ACK on hit. Sl_xferAck is registered high for exactly one cycle.
  - ACK → IDLE unconditionally.
  - Latency: a hit sampled at edge N produces Sl_xferAck high in cycle N+1.
  - A hit seen while Sl_xferAck is high is ignored, so back-to-back transfers are acked every other cycle at most.
- Write to DATA:
  - Commits at the same edge that raises Sl_xferAck.
  - Byte lane i updates only if OPB_BE[i] = 1.
  - Mapping: DBus[0:7] → user_data_out[31:24], …, DBus[24:31] → user_data_out[7:0].
  - user_data_valid pulses coincident with Sl_xferAck when at least one BE bit is set.
  - A write with BE = 0000 is acked: no change, no pulse.
- Read:
  - Sl_DBus carries the selected word only while Sl_xferAck = 1 and the transfer is a read; otherwise all zero (wired-OR bus).
  - A read of DATA returns the value before any same-cycle write; reads and writes never overlap.
- Reset values:
  - user_data_out = C_RESET_VAL.
  - user_data_valid, Sl_xferAck, Sl_DBus = 0.
  - WRCOUNT = 0.
  - FSM = IDLE.
- Reset mid-transfer:
  - An assert during ACK aborts the ack immediately and causes no partial write.
  - The master recovers by bus timeout.
- OPB_RNW, OPB_BE and OPB_DBus are sampled only at the hit edge.

Optional Feature:
- Macro: OPB_REG_WRCOUNT_EN.
- Defined:
  - A 32-bit counter increments on every write that pulses user_data_valid.
  - It wraps 0xFFFFFFFF → 0 and is readable at offset 0x4.
- Undefined:
  - No counter is built; offset 0x4 reads 0.
  - All other behaviour is identical.

Decomposition:
- Package opb_reg_pkg:
  - Offset constants OPB_REG_OFF_DATA = 4'h0 and OPB_REG_OFF_WRCOUNT = 4'h4.
  - The OPB data/address width constants.
  - Byte-lane mapping function be_merge(old, new, be).
- One sub-module, opb_slave_xfer_ctrl:
  - Holds the address decode, the IDLE/ACK FSM and the Sl_xferAck generation.
  - Reusable by sibling register slaves.

Test Plan:
- Reset:
  - Stimulus: assert OPB_Rst asynchronously mid-cycle with C_RESET_VAL = 32'hA5A5_0000.
  - Response: user_data_out = A5A50000 immediately; Sl_xferAck = 0.
- Full write:
  - Stimulus: write 0x12345678, BE = 1111, to 0x01080700.
  - Response: Sl_xferAck one cycle after select; user_data_out = 12345678 and user_data_valid high in that same cycle; Sl_DBus stays 0.
- Partial write:
  - Stimulus: write 0xFFFFFFFF with BE = 0100 after the full-write test.
  - Response: user_data_out = 12FF5678; one valid pulse.
- Readback and out-of-window:
  - Stimulus: read 0x01080700; read 0x01080800.
  - Response: first read returns Sl_DBus = 12FF5678 during the ack cycle only; second read gets no ack and all outputs 0.
- Back-to-back and BE = 0000:
  - Stimulus: OPB_select held high for 4 cycles on DATA writes; separately a write with BE = 0000.
  - Response: held select gives exactly 2 acks on alternating cycles; BE = 0000 write gives an ack but no valid pulse.
- WRCOUNT (OPB_REG_WRCOUNT_EN defined):
  - Stimulus: 3 effective writes, then read 0x01080704; force the counter to FFFFFFFF and write once more.
  - Response: read returns 3; forced counter reads 0 after the write. With the macro undefined, 0x01080704 reads 0.

Source files
------------

// File: rtl/opb_register_ppc2simulink_pkg.sv
// Shared constants, FSM state type and byte-lane merge helper for the OPB register slaves.
package opb_reg_pkg;

   localparam int unsigned OPB_AWIDTH  = 32;
   localparam int unsigned OPB_DWIDTH  = 32;
   localparam int unsigned OPB_BEWIDTH = OPB_DWIDTH / 8;

   localparam logic [3:0] OPB_REG_OFF_DATA    = 4'h0;
   localparam logic [3:0] OPB_REG_OFF_WRCOUNT = 4'h4;

   typedef enum logic {StIdle, StAck} xfer_state_e;

   // be[3] is OPB_BE[0] and covers the most significant byte once the
   // big-endian bus vectors are assigned to descending [31:0] vectors.
   function automatic logic [OPB_DWIDTH-1:0] be_merge(
      input logic [OPB_DWIDTH-1:0]  old_word,
      input logic [OPB_DWIDTH-1:0]  new_word,
      input logic [OPB_BEWIDTH-1:0] be
   );
      logic [OPB_DWIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < OPB_BEWIDTH; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_if.sv
// OPB master/slave signal bundle; bus vectors keep the OPB big-endian bit numbering.
interface opb_register_ppc2simulink_if;
   import opb_reg_pkg::*;

   logic [0:OPB_AWIDTH-1]  OPB_ABus;
   logic [0:OPB_BEWIDTH-1] OPB_BE;
   logic [0:OPB_DWIDTH-1]  OPB_DBus;
   logic                   OPB_RNW;
   logic                   OPB_select;
   logic                   OPB_seqAddr;
   logic [0:OPB_DWIDTH-1]  Sl_DBus;
   logic                   Sl_errAck;
   logic                   Sl_retry;
   logic                   Sl_toutSup;
   logic                   Sl_xferAck;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
   );

endinterface

// File: rtl/opb_register_ppc2simulink_xfer_ctrl.sv
// Address-window decode and IDLE/ACK handshake FSM shared by the OPB register slaves.
module opb_slave_xfer_ctrl
   import opb_reg_pkg::*;
#(
   parameter logic [OPB_AWIDTH-1:0] C_BASEADDR = 32'h01080700,
   parameter logic [OPB_AWIDTH-1:0] C_HIGHADDR = 32'h010807FF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_select,
   input  logic [OPB_AWIDTH-1:0] i_addr,
   output logic                  o_hit,
   output logic                  o_xfer_ack
);

   xfer_state_e r_state;
   xfer_state_e w_state_next;

   assign o_xfer_ack = (r_state == StAck);

   // Masking with the ack keeps a held select from being acked on consecutive cycles.
   assign o_hit = i_select && (i_addr >= C_BASEADDR) && (i_addr <= C_HIGHADDR) && !o_xfer_ack;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (o_hit) w_state_next = StAck;
         StAck:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// PPC-to-user-logic control register on OPB with byte-lane writes and an update strobe.
// Define OPB_REG_WRCOUNT_EN to build the write counter readable at offset 0x4.
module opb_register_ppc2simulink
   import opb_reg_pkg::*;
#(
   parameter logic [OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01080700,
   parameter logic [OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h010807FF,
   parameter int                    C_OPB_AWIDTH = 32,
   parameter int                    C_OPB_DWIDTH = 32,
   parameter logic [OPB_DWIDTH-1:0] C_RESET_VAL  = 32'h00000000,
   parameter                        C_FAMILY     = "virtex5"
) (
   input  logic                       OPB_Clk,
   input  logic                       OPB_Rst,
   opb_register_ppc2simulink_if.slave opb,
   output logic [OPB_DWIDTH-1:0]      user_data_out,
   output logic                       user_data_valid
);

   logic [OPB_AWIDTH-1:0]  w_addr;
   logic [OPB_DWIDTH-1:0]  w_wdata;
   logic [OPB_BEWIDTH-1:0] w_be;
   logic [5:0]             w_off;
   logic                   w_hit;
   logic                   w_xfer_ack;
   logic                   w_wr_en;
   logic [OPB_DWIDTH-1:0]  w_rd_word;
   logic                   w_unused_cfg;

   logic [OPB_DWIDTH-1:0]  r_data;
   logic [OPB_DWIDTH-1:0]  r_rdata;
   logic                   r_valid;

   // Big-endian bus vectors land MSB-first in the descending local copies.
   assign w_addr  = opb.OPB_ABus;
   assign w_wdata = opb.OPB_DBus;
   assign w_be    = opb.OPB_BE;
   assign w_off   = {w_addr[5:2], 2'b00};

   assign w_unused_cfg = ^{opb.OPB_seqAddr, C_OPB_AWIDTH, C_OPB_DWIDTH, C_FAMILY};

   opb_slave_xfer_ctrl #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_xfer_ctrl (
      .i_clk      (OPB_Clk),
      .i_rst      (OPB_Rst),
      .i_select   (opb.OPB_select),
      .i_addr     (w_addr),
      .o_hit      (w_hit),
      .o_xfer_ack (w_xfer_ack)
   );

   assign w_wr_en = w_hit && !opb.OPB_RNW && (w_off == {2'b00, OPB_REG_OFF_DATA}) && (|w_be);

`ifdef OPB_REG_WRCOUNT_EN
   logic [OPB_DWIDTH-1:0] r_wrcount;

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst)      r_wrcount <= '0;
      else if (w_wr_en) r_wrcount <= r_wrcount + 1'b1;
   end
`endif

   always_comb begin
      w_rd_word = '0;
      if (w_off == {2'b00, OPB_REG_OFF_DATA}) begin
         w_rd_word = r_data;
      end
`ifdef OPB_REG_WRCOUNT_EN
      else if (w_off == {2'b00, OPB_REG_OFF_WRCOUNT}) begin
         w_rd_word = r_wrcount;
      end
`endif
   end

   // Everything commits at the hit edge, so the ack cycle presents registered results only.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         r_data  <= C_RESET_VAL;
         r_rdata <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_wr_en;
         r_rdata <= (w_hit && opb.OPB_RNW) ? w_rd_word : '0;
         if (w_wr_en) r_data <= be_merge(r_data, w_wdata, w_be);
      end
   end

   assign opb.Sl_DBus     = r_rdata;
   assign opb.Sl_xferAck  = w_xfer_ack;
   assign opb.Sl_errAck   = 1'b0;
   assign opb.Sl_retry    = 1'b0;
   assign opb.Sl_toutSup  = 1'b0;
   assign user_data_out   = r_data;
   assign user_data_valid = r_valid;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed and randomized OPB transfers checked against a transaction-level register model.
module tb_opb_register_ppc2simulink;

   localparam logic [31:0] BASE    = 32'h01080700;
   localparam logic [31:0] HIGH    = 32'h010807FF;
   localparam logic [31:0] RST_VAL = 32'hA5A50000;

   logic        clk;
   logic        rst;
   logic [31:0] user_data_out;
   logic        user_data_valid;

   int n_cmp;
   int n_err;

   logic [31:0] model_data;
   logic [31:0] model_cnt;

   opb_register_ppc2simulink_if bus ();

   opb_register_ppc2simulink #(
      .C_BASEADDR   (BASE),
      .C_HIGHADDR   (HIGH),
      .C_OPB_AWIDTH (32),
      .C_OPB_DWIDTH (32),
      .C_RESET_VAL  (RST_VAL),
      .C_FAMILY     ("virtex5")
   ) dut (
      .OPB_Clk         (clk),
      .OPB_Rst         (rst),
      .opb             (bus),
      .user_data_out   (user_data_out),
      .user_data_valid (user_data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      case (addr[5:2])
         4'd0:    return model_data;
`ifdef OPB_REG_WRCOUNT_EN
         4'd1:    return model_cnt;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic bus_idle();
      bus.OPB_select  = 1'b0;
      bus.OPB_ABus    = '0;
      bus.OPB_BE      = '0;
      bus.OPB_DBus    = '0;
      bus.OPB_RNW     = 1'b0;
      bus.OPB_seqAddr = 1'b0;
   endtask

   task automatic bus_drive(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                            input logic [31:0] data);
      bus.OPB_ABus   = addr;
      bus.OPB_RNW    = rnw;
      bus.OPB_BE     = be;
      bus.OPB_DBus   = data;
      bus.OPB_select = 1'b1;
   endtask

   // Single transfer: predict from the model, drive for one edge, check ack cycle and the one after.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic rnw,
                       input logic [0:3] be, input logic [31:0] data);
      logic        in_win;
      logic [31:0] exp_rd;
      logic        exp_valid;
      in_win    = (addr >= BASE) && (addr <= HIGH);
      exp_rd    = 32'h0;
      exp_valid = 1'b0;
      if (in_win && rnw) exp_rd = model_read(addr);
      if (in_win && !rnw && addr[5:2] == 4'd0 && be != 4'b0000) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) model_data[31-8*i -: 8] = data[31-8*i -: 8];
         end
         model_cnt = model_cnt + 1;
         exp_valid = 1'b1;
      end
      @(negedge clk);
      bus_drive(addr, rnw, be, data);
      @(posedge clk);
      #1;
      bus_idle();
      chk({tag, ".ack"},   {31'h0, bus.Sl_xferAck}, {31'h0, in_win});
      chk({tag, ".dbus"},  bus.Sl_DBus, exp_rd);
      chk({tag, ".valid"}, {31'h0, user_data_valid}, {31'h0, exp_valid});
      chk({tag, ".udo"},   user_data_out, model_data);
      chk({tag, ".tied"},  {29'h0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
      @(posedge clk);
      #1;
      chk({tag, ".ack_off"},   {31'h0, bus.Sl_xferAck}, 32'h0);
      chk({tag, ".dbus_off"},  bus.Sl_DBus, 32'h0);
      chk({tag, ".valid_off"}, {31'h0, user_data_valid}, 32'h0);
   endtask

   initial begin
      logic [31:0] addr;
      logic [0:3]  be;
      logic [31:0] data;
      logic        rnw;
      n_cmp = 0;
      n_err = 0;
      bus_idle();
      rst = 1'b1;
      model_data = RST_VAL;
      model_cnt  = 32'h0;
      #2;
      chk("reset.udo",   user_data_out, RST_VAL);
      chk("reset.ack",   {31'h0, bus.Sl_xferAck}, 32'h0);
      chk("reset.dbus",  bus.Sl_DBus, 32'h0);
      chk("reset.valid", {31'h0, user_data_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Reset asserted in the middle of an ack cycle aborts it at once.
      @(negedge clk);
      bus_drive(BASE, 1'b0, 4'b1111, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      bus_idle();
      chk("rst_mid.ack_before", {31'h0, bus.Sl_xferAck}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid.ack",   {31'h0, bus.Sl_xferAck}, 32'h0);
      chk("rst_mid.udo",   user_data_out, RST_VAL);
      chk("rst_mid.valid", {31'h0, user_data_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      xfer("full_wr",  BASE,          1'b0, 4'b1111, 32'h12345678);
      chk("full_wr.model", model_data, 32'h12345678);
      xfer("part_wr",  BASE,          1'b0, 4'b0100, 32'hFFFFFFFF);
      chk("part_wr.model", model_data, 32'h12FF5678);
      xfer("rd_data",  BASE,          1'b1, 4'b1111, 32'h0);
      xfer("rd_out",   32'h01080800,  1'b1, 4'b1111, 32'h0);
      xfer("wr_out",   BASE - 32'd4,  1'b0, 4'b1111, 32'h0BADF00D);
      xfer("be_zero",  BASE,          1'b0, 4'b0000, 32'h55555555);
      xfer("wr_other", BASE + 32'h8,  1'b0, 4'b1111, 32'h77777777);

      // Select held for four edges: acks and strobes only on alternate cycles.
      @(negedge clk);
      bus_drive(BASE, 1'b0, 4'b1111, 32'hCAFEF00D);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("b2b.ack%0d", c), {31'h0, bus.Sl_xferAck}, (c % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("b2b.valid%0d", c), {31'h0, user_data_valid},
             (c % 2 == 0) ? 32'h1 : 32'h0);
      end
      bus_idle();
      model_data = 32'hCAFEF00D;
      model_cnt  = model_cnt + 2;
      @(posedge clk);
      #1;
      chk("b2b.ack_end", {31'h0, bus.Sl_xferAck}, 32'h0);
      chk("b2b.udo",     user_data_out, 32'hCAFEF00D);

      xfer("rd_cnt", BASE + 32'h4, 1'b1, 4'b1111, 32'h0);
`ifdef OPB_REG_WRCOUNT_EN
      @(negedge clk);
      force dut.r_wrcount = 32'hFFFFFFFF;
      #1;
      release dut.r_wrcount;
      model_cnt = 32'hFFFFFFFF;
      xfer("wrap_wr", BASE, 1'b0, 4'b0011, 32'h00009999);
      xfer("wrap_rd", BASE + 32'h4, 1'b1, 4'b1111, 32'h0);
      chk("wrap.model", model_cnt, 32'h0);
`endif

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0:       addr = BASE;
            1:       addr = BASE + 32'h4;
            2:       addr = BASE + 32'h8;
            3:       addr = BASE + 32'hFC;
            4:       addr = BASE - 32'h4;
            default: addr = HIGH + 32'h1;
         endcase
         rnw  = 1'($urandom_range(0, 1));
         be   = 4'($urandom_range(0, 15));
         data = $urandom;
         xfer($sformatf("rand%0d", n), addr, rnw, be, data);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
